// File: rtl/mlp_pkg.sv
// Shared MLP datapath definitions: lane geometry, activation FIFO depth and the row type.
// Used by the systolic array, the requant stage and the activation skew FIFO.
package mlp_pkg;
  localparam int LANES_DEF          = 8;
  localparam int DW_DEF             = 8;
  localparam int ACT_FIFO_DEPTH_DEF = 16;

  typedef logic [LANES_DEF*DW_DEF-1:0] row_t;
endpackage

// File: rtl/act_sync_fifo.sv
// Synchronous row FIFO: pointers, occupancy count, registered-count ready and the pop strobe.
// Reads are combinational from rd_ptr; a row written at edge t is poppable at edge t+1.
module act_sync_fifo
  import mlp_pkg::*;
#(
  parameter int W     = LANES_DEF * DW_DEF,
  parameter int DEPTH = ACT_FIFO_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          out_ready,
  output logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;

  // Ready looks only at the registered count, so a full FIFO refuses a push even on a pop cycle.
  assign in_ready = rst_n && (count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = out_ready && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; cleared pointers and count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
endmodule

// File: rtl/act_skew_fifo.sv
// Activation row buffer feeding the systolic array as a diagonal wavefront (lane j delayed j cycles).
// Stage k keeps only lanes k..LANES-1 of its row, since lower lanes have already been emitted.
module act_skew_fifo
  import mlp_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = ACT_FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DW-1:0]      in_data,
  input  logic                     out_ready,
  output logic [LANES*DW-1:0]      out_data,
  output logic [LANES-1:0]         out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);
  logic                pop;
  logic [LANES*DW-1:0] pop_data;

  act_sync_fifo #(.W(LANES*DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_ready (out_ready),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (count)
  );

  for (genvar k = 0; k < LANES; k++) begin : g_stage
    localparam int SW = (LANES - k) * DW;
    logic [SW-1:0] d;
    logic          v;
    logic [SW-1:0] src_d;
    logic          src_v;

    if (k == 0) begin : g_head
      // Bubbles load zero data so idle lanes read back as 0 all the way down the line.
      assign src_v = pop;
      assign src_d = pop ? pop_data : '0;
    end else begin : g_tail
      assign src_v = g_stage[k-1].v;
      assign src_d = g_stage[k-1].d[SW+DW-1:DW];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        d <= '0;
        v <= 1'b0;
      end else begin
        d <= src_d;
        v <= src_v;
      end
    end

    assign out_valid[k]         = v;
    assign out_data[k*DW +: DW] = d[DW-1:0];
  end

  assign busy = (count != '0) || (|out_valid);
endmodule

// File: tb/tb_act_skew_fifo.sv
// Self-checking bench for act_skew_fifo: queue-based FIFO model plus a per-cycle pop log that
// yields lane j from the row popped j edges ago; directed literal checks pin the model.
module tb_act_skew_fifo;
  import mlp_pkg::*;

  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int N     = 1024;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*DW-1:0]    in_data;
  logic                   out_ready;
  logic [LANES*DW-1:0]    out_data;
  logic [LANES-1:0]       out_valid;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  act_skew_fifo #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .count     (count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO contents as a queue, and a log of what was popped at each edge.
  row_t q[$];
  bit   pop_v [N];
  row_t pop_d [N];
  int   cyc = 0;

  always @(posedge clk) begin
    bit do_push, do_pop;
    cyc++;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i <= LANES; i++)
        if (cyc >= i) begin
          pop_v[(cyc-i)%N] = 1'b0;
          pop_d[(cyc-i)%N] = '0;
        end
    end else begin
      do_push = in_valid && (q.size() != DEPTH);
      do_pop  = out_ready && (q.size() != 0);
      pop_v[cyc%N] = do_pop;
      pop_d[cyc%N] = do_pop ? q[0] : '0;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(in_data);
    end
  end

  always @(posedge clk) begin
    logic [63:0] ed;
    logic [7:0]  ev;
    logic        eb;
    row_t        r;
    #1;
    ed = '0;
    ev = '0;
    for (int j = 0; j < LANES; j++)
      if (cyc >= j && pop_v[(cyc-j)%N]) begin
        ev[j] = 1'b1;
        r = pop_d[(cyc-j)%N];
        ed[j*DW +: DW] = r[j*DW +: DW];
      end
    eb = (q.size() != 0) || (ev != 0);
    check("in_ready",  64'(in_ready),  64'(rst_n && (q.size() != DEPTH)));
    check("count",     64'(count),     64'(q.size()));
    check("busy",      64'(busy),      64'(eb));
    check("out_valid", 64'(out_valid), 64'(ev));
    check("out_data",  out_data,       ed);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);

    // Reset release
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_count",     64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'h00);
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_in_ready",  64'(in_ready), 64'd1);

    // Single row: lane j shows j+1 in the cycle after edge t+1+j
    in_valid = 1'b1;
    in_data = 64'h0807060504030201;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      @(posedge clk);
      #2;
      check("single_valid", 64'(out_valid), 64'(8'h01 << j));
      check("single_lane",  64'(out_data[j*DW +: DW]), 64'(j + 1));
    end
    @(posedge clk);
    #2;
    check("single_busy_drop", 64'(busy), 64'd0);

    // Eight back-to-back rows form a full diagonal
    for (int k = 0; k < LANES; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = {8{8'(k + 1)}};
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("diag_full", 64'(out_valid), 64'hFF);
    for (int j = 0; j < LANES; j++)
      check("diag_lane", 64'(out_data[j*DW +: DW]), 64'(8 - j));
    repeat (10) @(posedge clk);

    // Fill with out_ready low; 17th push ignored
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = {$urandom, $urandom};
    end
    @(negedge clk);
    check("full_count",    64'(count), 64'd16);
    check("full_in_ready", 64'(in_ready), 64'd0);

    // Full: push and pop together -> only the pop happens
    out_ready = 1'b1;
    in_data = {$urandom, $urandom};
    @(posedge clk);
    #2;
    check("full_pushpop_count", 64'(count), 64'd15);

    // Alternating out_ready creates bubbles on alternate diagonals
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = (i % 2 == 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    repeat (30) @(posedge clk);

    // Mid-stream reset with 5 buffered and 3 in skew
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = {$urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("pre_rst_count", 64'(count), 64'd5);
    check("pre_rst_valid", 64'(out_valid), 64'h07);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_count",     64'(count), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'h00);
    check("mid_rst_busy",      64'(busy), 64'd0);
    check("mid_rst_in_ready",  64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (12) @(posedge clk);

    // Random valid/ready traffic
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      in_data   = {$urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    check("final_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
